// File: rtl/hilo_muldiv_if.sv
// HI/LO multiply-divide unit bus: EX-stage request, HI/LO read mux and status.
// Latency: n/a (wiring only).
// Backpressure: busy is the stall request; the master holds off new requests while it is high.
//
// Signals:
//   start, funct, a, b   request from EX (funct = R-type funct field)
//   read_hilo            0 selects HI, 1 selects LO onto hilo_out
//   hilo_out, hi, lo     register pair and its read mux
//   busy, done, div_by_zero  status back to the hazard unit / pipeline
interface hilo_muldiv_if;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        read_hilo;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  // master = EX stage / decoder side, slave = the multiply-divide unit
  modport master (
    output start, funct, a, b, read_hilo,
    input  hilo_out, hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, funct, a, b, read_hilo,
    output hilo_out, hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle mult/multu/div/divu unit owning the MIPS HI/LO pair; also mthi/mtlo.
// Latency: start at edge k -> HI/LO at k+33 (iterative), k+1 for divide-by-zero, k for mthi/mtlo.
// Backpressure: busy asserted while an operation is in flight; start is ignored while busy.
//
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset (IDLE, HI = LO = 0, status low)
//   mdu     hilo_muldiv_if.slave: start/funct/a/b request, read_hilo select,
//           hilo_out/hi/lo registers, busy/done/div_by_zero status
//
// Build option: define HILO_FAST_MUL_EN to replace the 32-cycle shift-add
// multiplier with a single-cycle combinational one (mult/multu then finish at k+1).
module hilo_muldiv (
  input  logic          clk_i,
  input  logic          rst_ni,
  hilo_muldiv_if.slave  mdu
);

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]  state_q,     state_d;
  logic [4:0]  cnt_q,       cnt_d;
  logic [63:0] acc_q,       acc_d;
  logic [31:0] opa_q,       opa_d;      // |multiplicand| or |dividend| (shifted out MSB-first)
  logic [31:0] opb_q,       opb_d;      // |multiplier| (shifted out LSB-first) or |divisor|
  logic        is_div_q,    is_div_d;
  logic        neg_res_q,   neg_res_d;  // operand signs differ: negate product / quotient
  logic        neg_rem_q,   neg_rem_d;  // dividend negative: negate remainder
  logic        dbz_q,       dbz_d;
  logic [31:0] hi_q,        hi_d;
  logic [31:0] lo_q,        lo_d;
  logic        done_q,      done_d;
  logic        dbz_pulse_q, dbz_pulse_d;

  // Request decode
  logic        req_mul, req_div, req_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;

  always_comb begin
    req_mul    = (mdu.funct == FN_MULT) || (mdu.funct == FN_MULTU);
    req_div    = (mdu.funct == FN_DIV)  || (mdu.funct == FN_DIVU);
    req_signed = (mdu.funct == FN_MULT) || (mdu.funct == FN_DIV);
    a_neg      = req_signed & mdu.a[31];
    b_neg      = req_signed & mdu.b[31];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    a_abs      = a_neg ? (32'd0 - mdu.a) : mdu.a;
    b_abs      = b_neg ? (32'd0 - mdu.b) : mdu.b;
  end

  // One shift-add multiply step: add the multiplicand into the upper half when
  // the current multiplier bit is set, then shift the 65-bit result right.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (opb_q[0] ? opa_q : 32'd0)};
    mul_next = {mul_sum, acc_q[31:1]};
  end

  // One restoring-divide step: acc[63:32] is the partial remainder, acc[31:0]
  // collects quotient bits. The remainder is always below the divisor, so it
  // fits 32 bits after the step; diff[32] set means the trial subtract failed.
  logic [32:0] rem_sh;
  logic [32:0] div_diff;
  logic [63:0] div_next;

  always_comb begin
    rem_sh   = {acc_q[63:32], opa_q[31]};
    div_diff = rem_sh - {1'b0, opb_q};
    if (div_diff[32]) begin
      div_next = {rem_sh[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
  end

  // Sign correction applied in FIX. Divide-by-zero enters FIX with both
  // negate flags clear, so acc passes straight through as {A, 0xFFFFFFFF}.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] fix_hi, fix_lo;

  always_comb begin
    prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_res_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    if (is_div_q) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end else begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    is_div_d    = is_div_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dbz_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mdu.start) begin
          if (req_mul || req_div) begin
            opa_d     = a_abs;
            opb_d     = b_abs;
            is_div_d  = req_div;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dbz_d     = 1'b0;
            cnt_d     = 5'd0;
            acc_d     = 64'd0;
            state_d   = ST_RUN;
            if (req_div && (mdu.b == 32'd0)) begin
              // No iteration: FIX publishes HI = A, LO = all ones.
              acc_d     = {mdu.a, 32'hFFFF_FFFF};
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
              dbz_d     = 1'b1;
              state_d   = ST_FIX;
            end
`ifdef HILO_FAST_MUL_EN
            if (req_mul) begin
              acc_d   = {32'd0, a_abs} * {32'd0, b_abs};
              state_d = ST_FIX;
            end
`endif
          end else if (mdu.funct == FN_MTHI) begin
            hi_d = mdu.a;
          end else if (mdu.funct == FN_MTLO) begin
            lo_d = mdu.a;
          end
        end
      end

      ST_RUN: begin
        if (is_div_q) begin
          acc_d = div_next;
          opa_d = {opa_q[30:0], 1'b0};
        end else begin
          acc_d = mul_next;
          opb_d = {1'b0, opb_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        hi_d        = fix_hi;
        lo_d        = fix_lo;
        done_d      = 1'b1;
        dbz_pulse_d = dbz_q;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      acc_q       <= 64'd0;
      opa_q       <= 32'd0;
      opb_q       <= 32'd0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      done_q      <= 1'b0;
      dbz_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      is_div_q    <= is_div_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
      dbz_pulse_q <= dbz_pulse_d;
    end
  end

  assign mdu.hi          = hi_q;
  assign mdu.lo          = lo_q;
  assign mdu.hilo_out    = mdu.read_hilo ? lo_q : hi_q;
  assign mdu.busy        = (state_q != ST_IDLE);
  assign mdu.done        = done_q;
  assign mdu.div_by_zero = dbz_pulse_q;

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit that owns the HI/LO register pair in the EX stage of the pipelined MIPS datapath. It executes mult/multu/div/divu and mthi/mtlo. It drives the HI or LO value selected by the decoder's HI/LO select bit (0 = HI, 1 = LO) into the write-back mux for mfhi/mflo. While an iterative operation runs, it asserts a stall to the hazard unit.

## Interface
- Parameters: none.
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  EX stage holds a valid instruction for this unit; sampled on Clk rising edge.
- Funct  in  6  R-type funct field: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo.
- A  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- B  in  32  rt operand (divisor / multiplier).
- ReadHiLo  in  1  0 selects HI, 1 selects LO onto HiLoOut.
- HiLoOut  out  32  combinational mux of Hi/Lo per ReadHiLo.
- Hi  out  32  HI register.
- Lo  out  32  LO register.
- Busy  out  1  iterative operation in progress; pipeline must stall.
- Done  out  1  one-cycle pulse: Hi/Lo just updated by a mul/div.
- DivByZero  out  1  one-cycle pulse, coincident with Done, for a divide with B = 0.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, Start=1, mul/div funct:
  - Latch operand signs (signed ops only) and absolute values.
  - Clear the 64-bit accumulator and 5-bit counter.
  - Go to RUN.
- IDLE, Start=1, mthi/mtlo: write A into Hi/Lo at that edge. Stay IDLE; no Busy, no Done.
- IDLE, Start=1, any other funct: ignored.
- Start while Busy: ignored (the stall guarantees it does not occur in normal flow).
- RUN, multiply: unsigned shift-add, one multiplier bit per cycle, 32 cycles.
- RUN, divide: restoring division, one quotient bit per cycle, 32 cycles.
- RUN ends when the counter reaches 31, then go to FIX.
- FIX applies sign correction:
  - Product negated (64-bit two's complement) if signs differ.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - Quotient truncates toward zero.
  - FIX writes Hi (product[63:32] / remainder) and Lo (product[31:0] / quotient), pulses Done, and returns to IDLE.
- Unsigned ops skip negation; FIX is still taken, so latency is uniform.
- 0x80000000 / -1 (signed): Lo = 0x80000000, Hi = 0; no exception.
- Divide with B = 0:
  - Skips RUN; IDLE goes directly to FIX.
  - Hi = A, Lo = 0xFFFFFFFF; Done and DivByZero pulse.
- Hi/Lo are never partially updated; until FIX they hold prior values.

## Timing
- Reset (async, Rst low): state IDLE, Hi = 0, Lo = 0, Busy = 0, Done = 0, DivByZero = 0, counter = 0.
- Reset during RUN/FIX aborts the operation; Hi/Lo clear to 0.
- Start accepted at edge k (mul/div, B≠0 for div):
  - Busy = 1 from after edge k through edge k+33.
  - Hi/Lo update at edge k+33.
  - Done = 1 for the cycle following edge k+33.
  - Busy = 0 in that same cycle.
- Divide by zero: Busy high for 1 cycle; Hi/Lo update at edge k+1.
- mthi/mtlo: Hi/Lo update at edge k; back-to-back writes allowed every cycle.
- HiLoOut is combinational from the registers and ReadHiLo (zero latency). An mfhi in the cycle after Done reads the new value.

## Configuration
- HILO_FAST_MUL_EN defined:
  - mult/multu compute the product with a single-cycle combinational multiplier.
  - IDLE goes to FIX directly; Busy high for 1 cycle; Hi/Lo update at edge k+1.
  - Divide is unchanged.
- Not defined: multiply uses the 32-cycle iterative path described above.

## Test plan
- Reset with Rst=0 mid-RUN (cycle 10 of a div) -> Busy = 0 immediately, Hi = Lo = 0, state IDLE; next mult starts normally.
- mult A=0xFFFFFFFD (-3), B=7 -> after 33 Busy cycles: Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB, one Done pulse.
- multu A=B=0xFFFFFFFF -> Hi = 0xFFFFFFFE, Lo = 0x00000001.
- div A=0xFFFFFFF9 (-7), B=2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF; div A=0x80000000, B=0xFFFFFFFF -> Lo = 0x80000000, Hi = 0.
- divu A=100, B=0 -> Busy for 1 cycle; Hi = 100, Lo = 0xFFFFFFFF; DivByZero and Done pulse together.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles; ReadHiLo 0 then 1 -> HiLoOut = 0x12345678 then 0x9ABCDEF0. Start during Busy is ignored and Hi/Lo are unchanged.
